uart_tx_frame: RTL and testbench

//   UART transmitter: serialises one byte per request onto the tx line with its
//   own baud-interval counter (one full bit period per bit, no mid-bit strobe).

---
 rtl/uart_tx_frame.sv | 134 +++++++++++++
 tb/tb_uart_tx_frame.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: byte-wide UART transmitter with its own full-bit baud counter.
// Frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Handshake: tx_start is accepted only while tx_ready is high. tx_done pulses
// for one cycle, together with tx_ready rising, after the last stop bit.
module uart_tx_frame #(
  parameter int unsigned BPS_DIV   = 868,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx
);

  // Parameter sanity, reported at elaboration in simulation.
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (BPS_DIV < 2 || BPS_DIV > 8191) begin : g_bad_div
    $error("uart_tx_frame: BPS_DIV must be in 2..8191");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [12:0] BAUD_LAST = 13'(BPS_DIV - 1);
  localparam logic        ODD_PAR   = (PARITY == 2);
  localparam logic        USE_PAR   = (PARITY != 0);
  localparam logic        LAST_STOP = (STOP_BITS == 2);

  state_t      state;
  logic [12:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        par_bit;
  logic        stop_idx;
  logic        baud_wrap;

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // Frame sequencer: the next bit value is loaded into tx on the wrap edge of
  // the current bit, so tx stays a registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == S_IDLE || baud_wrap) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 13'd1;
      end
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            shreg    <= tx_data;
            par_bit  <= (^tx_data) ^ ODD_PAR;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_wrap) begin
            tx    <= shreg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) begin
              if (USE_PAR) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (baud_wrap) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_wrap) begin
            if (stop_idx == LAST_STOP) begin
              tx_ready <= 1'b1;
              tx_done  <= 1'b1;
              state    <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: five instances cover 8N1, even/odd parity,
// two stop bits and the full-rate divider. Expected serial bits are queued
// when a frame is requested and popped as the line is observed.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] start;
  logic [4:0] rdy;
  logic [4:0] done;
  logic [4:0] txl;
  logic [7:0] data [5];

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.BPS_DIV(16), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_start(start[0]), .tx_data(data[0]),
    .tx_ready(rdy[0]), .tx_done(done[0]), .tx(txl[0]));
  uart_tx_frame #(.BPS_DIV(16), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_start(start[1]), .tx_data(data[1]),
    .tx_ready(rdy[1]), .tx_done(done[1]), .tx(txl[1]));
  uart_tx_frame #(.BPS_DIV(16), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_start(start[2]), .tx_data(data[2]),
    .tx_ready(rdy[2]), .tx_done(done[2]), .tx(txl[2]));
  uart_tx_frame #(.BPS_DIV(16), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_start(start[3]), .tx_data(data[3]),
    .tx_ready(rdy[3]), .tx_done(done[3]), .tx(txl[3]));
  uart_tx_frame #(.BPS_DIV(868), .PARITY(0), .STOP_BITS(1)) u4 (
    .clk(clk), .rst(rst), .tx_start(start[4]), .tx_data(data[4]),
    .tx_ready(rdy[4]), .tx_done(done[4]), .tx(txl[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bps_of(input int i);
    return (i == 4) ? 868 : 16;
  endfunction

  function automatic int nbits_of(input int i);
    return 10 + ((i == 1 || i == 2) ? 1 : 0) + ((i == 3) ? 1 : 0);
  endfunction

  // Request a frame on lane i and queue its expected line bits.
  task automatic send(input int i, input logic [7:0] d);
    chk($sformatf("u%0d_ready_before", i), 32'(rdy[i]), 32'd1);
    data[i]  = d;
    start[i] = 1'b1;
    exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
    if (i == 1) exp_q.push_back(^d);
    if (i == 2) exp_q.push_back(~^d);
    exp_q.push_back(1'b1);
    if (i == 3) exp_q.push_back(1'b1);
    tick();
    start[i] = 1'b0;
  endtask

  // Called in the first cycle after accept. Checks each bit at its first and
  // last cycle (exact width), busy handshake, and the done cycle.
  task automatic frame_check(input int i, input bit disturb);
    int  bps;
    int  n;
    bit  cur;
    bps = bps_of(i);
    n   = nbits_of(i);
    cur = 1'b1;
    for (int j = 0; j < n * bps; j++) begin
      if (j % bps == 0) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else cur = exp_q.pop_front();
      end
      if (j % bps == 0 || j % bps == bps - 1)
        chk($sformatf("u%0d_bit%0d_c%0d", i, j / bps, j % bps), 32'(txl[i]), 32'(cur));
      if (j == 0 || j == n * bps - 1) begin
        chk($sformatf("u%0d_busy_j%0d", i, j), 32'(rdy[i]), 32'd0);
        chk($sformatf("u%0d_nodone_j%0d", i, j), 32'(done[i]), 32'd0);
      end
      if (disturb && j == 40) begin
        start[i] = 1'b1;
        data[i]  = ~data[i];
      end
      if (disturb && j == 45) start[i] = 1'b0;
      tick();
    end
    chk($sformatf("u%0d_done", i), 32'(done[i]), 32'd1);
    chk($sformatf("u%0d_ready_at_done", i), 32'(rdy[i]), 32'd1);
    chk($sformatf("u%0d_tx_at_done", i), 32'(txl[i]), 32'd1);
  endtask

  initial begin
    int pulses;
    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < 5; i++) data[i] = '0;
    #2;
    chk("rst_tx", 32'(txl), 32'h1f);
    chk("rst_ready", 32'(rdy), 32'h1f);
    chk("rst_done", 32'(done), 32'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // 8N1 alternating pattern, then done is a single-cycle pulse
    send(0, 8'h55);
    frame_check(0, 1'b0);
    tick();
    chk("u0_done_one_cycle", 32'(done[0]), 32'd0);

    // even and odd parity on the same byte
    send(1, 8'h07);
    frame_check(1, 1'b0);
    send(2, 8'h07);
    frame_check(2, 1'b0);

    // two stop bits, second request in the done cycle abuts the first frame
    send(3, 8'hC4);
    frame_check(3, 1'b0);
    send(3, 8'h3B);
    frame_check(3, 1'b0);

    // request and data change while busy must not disturb the frame
    tick();
    send(0, 8'h96);
    frame_check(0, 1'b1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done[0]) pulses++;
    end
    chk("u0_single_done", 32'(pulses), 32'd0);
    chk("u0_idle_line", 32'(txl[0]), 32'd1);

    // asynchronous reset mid-frame
    send(0, 8'hF0);
    repeat (50) tick();
    chk("u0_busy_mid", 32'(rdy[0]), 32'd0);
    exp_q.delete();
    #3 rst = 1'b1;
    #1;
    chk("arst_tx", 32'(txl), 32'h1f);
    chk("arst_ready", 32'(rdy), 32'h1f);
    chk("arst_done", 32'(done), 32'h0);
    #2 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (done[0] || !txl[0]) pulses++;
    end
    chk("arst_no_done_after", 32'(pulses), 32'd0);

    // full-rate divider, exact 868-cycle bit widths
    send(4, 8'hA3);
    frame_check(4, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
